// File: rtl/io_pkg.sv
// rtl/io_pkg.sv - register offsets and bit indices for the io_port_ctrl window
package io_pkg;

    // Register offsets from BASE
    localparam logic [1:0] OFS_OUT    = 2'd0;
    localparam logic [1:0] OFS_STATUS = 2'd1;
    localparam logic [1:0] OFS_IN     = 2'd2;
    localparam logic [1:0] OFS_CTRL   = 2'd3;

    // STATUS bit indices; FIFO count occupies [ST_COUNT_W-1:0]
    localparam int ST_OVERFLOW = 15;
    localparam int ST_IN_LOST  = 14;
    localparam int ST_IN_VALID = 13;
    localparam int ST_FULL     = 12;
    localparam int ST_EMPTY    = 11;
    localparam int ST_COUNT_W  = 8;

    // CTRL bit indices
    localparam int CTRL_FLUSH     = 0;
    localparam int CTRL_CLR_FLAGS = 1;

endpackage

// File: rtl/io_port_ctrl_if.sv
// rtl/io_port_ctrl_if.sv - CPU bus, output stream and input capture signals of io_port_ctrl
interface io_port_ctrl_if #(
    parameter int DW = 16,
    parameter int AW = 16
);
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic          we;
    logic          re;
    logic [DW-1:0] rdata;
    logic          hit;
    logic [DW-1:0] out_data;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] in_data;
    logic          in_strobe;

    // CPU / external device side
    modport master (
        output addr, wdata, we, re, out_ready, in_data, in_strobe,
        input  rdata, hit, out_data, out_valid
    );

    // Controller side
    modport slave (
        input  addr, wdata, we, re, out_ready, in_data, in_strobe,
        output rdata, hit, out_data, out_valid
    );
endinterface

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - single-clock FIFO with flush; push accepted on full when a pop coincides
module sync_fifo #(
    parameter int DW    = 16,
    parameter int DEPTH = 8,
    localparam int PW   = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          i_flush,
    input  logic          i_push,
    input  logic [DW-1:0] i_push_data,
    input  logic          i_pop,
    output logic [DW-1:0] o_head_data,
    output logic          o_full,
    output logic          o_empty,
    output logic [PW:0]   o_count,
    output logic          o_push_ok
);

    localparam logic [PW:0] FULL_CNT = (PW+1)'(DEPTH);
    localparam logic [PW:0] ONE_CNT  = (PW+1)'(1);
    localparam logic [PW-1:0] ONE_PTR = PW'(1);

    logic [DW-1:0] r_mem [DEPTH];
    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_rd_ptr;
    logic [PW:0]   r_count;

    logic w_pop;
    logic w_push_ok;

    assign o_full      = (r_count == FULL_CNT);
    assign o_empty     = (r_count == '0);
    assign w_pop       = i_pop && !o_empty;
    assign w_push_ok   = i_push && (!o_full || w_pop);
    assign o_push_ok   = w_push_ok;
    assign o_count     = r_count;
    // Head reads as zero when empty so stale storage never leaks out after reset/flush
    assign o_head_data = o_empty ? '0 : r_mem[r_rd_ptr];

    // Storage write; contents need no reset because the head is masked while empty
    always_ff @(posedge clk) begin
        if (w_push_ok && !i_flush) begin
            r_mem[r_wr_ptr] <= i_push_data;
        end
    end

    // Pointer and count update; flush overrides any same-cycle push or pop
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push_ok) begin
                r_wr_ptr <= r_wr_ptr + ONE_PTR;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + ONE_PTR;
            end
            if (w_push_ok && !w_pop) begin
                r_count <= r_count + ONE_CNT;
            end else if (w_pop && !w_push_ok) begin
                r_count <= r_count - ONE_CNT;
            end
        end
    end

endmodule

// File: rtl/io_port_ctrl.sv
// rtl/io_port_ctrl.sv - memory-mapped I/O window: output FIFO, input holding register, status; option IO_PORT_OVERFLOW_EN
module io_port_ctrl
    import io_pkg::*;
#(
    parameter int            DW    = 16,
    parameter int            AW    = 16,
    parameter logic [AW-1:0] BASE  = 16'hFF00,
    parameter int            DEPTH = 8,
    localparam int           PW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          reset,
    io_port_ctrl_if.slave bus
);

    logic [1:0]    w_ofs;
    logic          w_hit;
    logic          w_wr_out;
    logic          w_wr_ctrl;
    logic          w_rd_in;
    logic          w_flush;
    logic          w_clr_flags;
    logic          w_full;
    logic          w_empty;
    logic [PW:0]   w_count;
    logic          w_push_ok;
    logic          w_ovf_evt;
    logic          w_overflow;
    logic [DW-1:0] w_status;
    logic [DW-1:0] w_rdata;

    logic [DW-1:0] r_hold;
    logic          r_in_valid;
    logic          r_in_lost;

    assign w_ofs       = bus.addr[1:0];
    assign w_hit       = (bus.addr[AW-1:2] == BASE[AW-1:2]);
    assign w_wr_out    = bus.we && w_hit && (w_ofs == OFS_OUT);
    assign w_wr_ctrl   = bus.we && w_hit && (w_ofs == OFS_CTRL);
    assign w_rd_in     = bus.re && w_hit && (w_ofs == OFS_IN);
    assign w_flush     = w_wr_ctrl && bus.wdata[CTRL_FLUSH];
    assign w_clr_flags = w_wr_ctrl && bus.wdata[CTRL_CLR_FLAGS];
    assign w_ovf_evt   = w_wr_out && !w_push_ok;

    sync_fifo #(
        .DW    (DW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk         (clk),
        .reset       (reset),
        .i_flush     (w_flush),
        .i_push      (w_wr_out),
        .i_push_data (bus.wdata),
        .i_pop       (bus.out_ready),
        .o_head_data (bus.out_data),
        .o_full      (w_full),
        .o_empty     (w_empty),
        .o_count     (w_count),
        .o_push_ok   (w_push_ok)
    );

    assign bus.out_valid = !w_empty;
    assign bus.hit       = w_hit;
    assign bus.rdata     = w_rdata;

`ifdef IO_PORT_OVERFLOW_EN
    logic r_overflow;

    // Sticky overflow on a rejected push; a new event beats a same-cycle clear
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_overflow <= 1'b0;
        end else if (w_ovf_evt) begin
            r_overflow <= 1'b1;
        end else if (w_clr_flags) begin
            r_overflow <= 1'b0;
        end
    end

    assign w_overflow = r_overflow;
`else
    logic w_unused_ovf;

    assign w_unused_ovf = w_ovf_evt;
    assign w_overflow   = 1'b0;
`endif

    // Input capture; a strobe always loads, an IN read alone consumes the word
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_hold     <= '0;
            r_in_valid <= 1'b0;
        end else if (bus.in_strobe) begin
            r_hold     <= bus.in_data;
            r_in_valid <= 1'b1;
        end else if (w_rd_in) begin
            r_in_valid <= 1'b0;
        end
    end

    // Sticky in_lost when an unread word is overwritten; set beats a same-cycle clear
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_in_lost <= 1'b0;
        end else if (bus.in_strobe && r_in_valid && !w_rd_in) begin
            r_in_lost <= 1'b1;
        end else if (w_clr_flags) begin
            r_in_lost <= 1'b0;
        end
    end

    // STATUS word assembled from registered state
    always_comb begin
        w_status                   = '0;
        w_status[ST_OVERFLOW]      = w_overflow;
        w_status[ST_IN_LOST]       = r_in_lost;
        w_status[ST_IN_VALID]      = r_in_valid;
        w_status[ST_FULL]          = w_full;
        w_status[ST_EMPTY]         = w_empty;
        w_status[ST_COUNT_W-1:0]   = ST_COUNT_W'(w_count);
    end

    // Combinational read mux so a load completes in the same cycle
    always_comb begin
        w_rdata = '0;
        if (bus.re && w_hit) begin
            case (w_ofs)
                OFS_STATUS: w_rdata = w_status;
                OFS_IN:     w_rdata = r_hold;
                default:    w_rdata = '0;
            endcase
        end
    end

endmodule

// File: tb/tb_io_port_ctrl.sv
// tb/tb_io_port_ctrl.sv - self-checking bench for io_port_ctrl with a queue-based reference model
module tb_io_port_ctrl;

    localparam int          DEPTH = 8;
    localparam logic [15:0] BASE  = 16'hFF00;
`ifdef IO_PORT_OVERFLOW_EN
    localparam bit OVF_EN = 1'b1;
`else
    localparam bit OVF_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset = 1'b1;
    bit   rdy = 1'b0;
    int   n_checks = 0;
    int   n_pass = 0;

    always #5 clk = ~clk;

    io_port_ctrl_if #(.DW(16), .AW(16)) bus ();

    io_port_ctrl #(
        .DW    (16),
        .AW    (16),
        .BASE  (BASE),
        .DEPTH (DEPTH)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Reference model state
    logic [15:0] mq[$];
    bit          m_ovf;
    bit          m_lost;
    bit          m_inv;
    logic [15:0] m_hold;

    bit m_hit, m_wr_out, m_wr_ctrl, m_rd_in, m_pop, m_acc;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    function automatic bit in_window(input logic [15:0] a);
        return a[15:2] == BASE[15:2];
    endfunction

    function automatic logic [15:0] exp_rdata();
        logic [15:0] a;
        a = bus.addr;
        if (!(bus.re && in_window(a))) return 16'h0000;
        case (a - BASE)
            16'd1: return {(OVF_EN ? m_ovf : 1'b0), m_lost, m_inv,
                           mq.size() == DEPTH, mq.size() == 0, 3'b000, 8'(mq.size())};
            16'd2: return m_hold;
            default: return 16'h0000;
        endcase
    endfunction

    // Model: evaluate the register-map rules once per clock edge
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            mq.delete();
            m_ovf = 0; m_lost = 0; m_inv = 0; m_hold = 16'h0000;
        end else begin
            m_hit     = in_window(bus.addr);
            m_wr_out  = bus.we && m_hit && (bus.addr - BASE == 16'd0);
            m_wr_ctrl = bus.we && m_hit && (bus.addr - BASE == 16'd3);
            m_rd_in   = bus.re && m_hit && (bus.addr - BASE == 16'd2);
            m_pop     = (mq.size() > 0) && bus.out_ready;
            m_acc     = (mq.size() < DEPTH) || m_pop;
            if (m_wr_ctrl && bus.wdata[1]) begin
                m_ovf = 0; m_lost = 0;
            end
            if (m_wr_ctrl && bus.wdata[0]) begin
                mq.delete();
            end else begin
                if (m_pop) void'(mq.pop_front());
                if (m_wr_out) begin
                    if (m_acc) mq.push_back(bus.wdata);
                    else m_ovf = 1;
                end
            end
            if (bus.in_strobe) begin
                if (m_inv && !m_rd_in) m_lost = 1;
                m_hold = bus.in_data;
                m_inv  = 1;
            end else if (m_rd_in) begin
                m_inv = 0;
            end
        end
    end

    // Compare process: outputs against the model every mid-cycle
    always @(negedge clk) begin
        if (!reset) begin
            chk("out_valid", 16'(bus.out_valid), 16'(mq.size() != 0));
            chk("out_data", bus.out_data, (mq.size() != 0) ? mq[0] : 16'h0000);
            chk("hit", 16'(bus.hit), 16'(in_window(bus.addr)));
            chk("rdata", bus.rdata, exp_rdata());
        end
    end

    task automatic drv(input logic [15:0] a, input logic [15:0] d, input bit w, input bit r,
                       input bit s, input logic [15:0] sd);
        @(posedge clk);
        #1;
        bus.addr = a; bus.wdata = d; bus.we = w; bus.re = r;
        bus.in_strobe = s; bus.in_data = sd; bus.out_ready = rdy;
    endtask

    task automatic idle();
        drv(16'h0000, 16'h0000, 0, 0, 0, 16'h0000);
    endtask

    task automatic wr(input logic [15:0] a, input logic [15:0] d);
        drv(a, d, 1, 0, 0, 16'h0000);
    endtask

    task automatic rd(input logic [15:0] a);
        drv(a, 16'h0000, 0, 1, 0, 16'h0000);
    endtask

    task automatic strobe(input logic [15:0] d);
        drv(16'h0000, 16'h0000, 0, 0, 1, d);
    endtask

    initial begin
        logic [15:0] exp_word;
        int sel;

        bus.addr = '0; bus.wdata = '0; bus.we = 0; bus.re = 0;
        bus.in_strobe = 0; bus.in_data = '0; bus.out_ready = 0;
        #1;
        chk("reset_rdata", bus.rdata, 16'h0000);
        chk("reset_out_valid", 16'(bus.out_valid), 16'h0000);
        chk("reset_out_data", bus.out_data, 16'h0000);
        repeat (3) @(posedge clk);
        #1 reset = 0;

        // Two words, status, then drain in order
        rdy = 0;
        wr(16'hFF00, 16'hA5A5);
        wr(16'hFF00, 16'h1234);
        rd(16'hFF01);
        @(negedge clk); chk("status_cnt2", bus.rdata, 16'h0002);
        rdy = 1;
        idle(); @(negedge clk); chk("drain_first", bus.out_data, 16'hA5A5);
        idle(); @(negedge clk); chk("drain_second", bus.out_data, 16'h1234);
        idle(); @(negedge clk); chk("drain_empty", 16'(bus.out_valid), 16'h0000);

        // Overfill by one, then clear flags
        rdy = 0;
        for (int i = 1; i <= 9; i++) wr(16'hFF00, 16'(i));
        rd(16'hFF01);
        @(negedge clk); chk("status_full", bus.rdata, OVF_EN ? 16'h9008 : 16'h1008);
        wr(16'hFF03, 16'h0002);
        rd(16'hFF01);
        @(negedge clk); chk("status_ovf_clr", bus.rdata, 16'h1008);

        // Push on full with simultaneous pop
        rdy = 1;
        wr(16'hFF00, 16'h00FF);
        rdy = 0;
        rd(16'hFF01);
        @(negedge clk); chk("status_full_pushpop", bus.rdata, 16'h1008);
        rdy = 1;
        for (int k = 0; k < 8; k++) begin
            exp_word = (k < 7) ? 16'(k + 2) : 16'h00FF;
            idle(); @(negedge clk); chk("drain_order", bus.out_data, exp_word);
        end
        idle(); @(negedge clk); chk("drain_order_empty", 16'(bus.out_valid), 16'h0000);
        rdy = 0;

        // Input capture, read, loss
        strobe(16'hBEEF);
        rd(16'hFF01); @(negedge clk); chk("status_in_valid", bus.rdata, 16'h2800);
        rd(16'hFF02); @(negedge clk); chk("in_read", bus.rdata, 16'hBEEF);
        rd(16'hFF01); @(negedge clk); chk("status_in_consumed", bus.rdata, 16'h0800);
        strobe(16'h1111);
        strobe(16'h2222);
        rd(16'hFF01); @(negedge clk); chk("status_in_lost", bus.rdata, 16'h6800);

        // Strobe coinciding with an IN read
        strobe(16'hBEEF);
        wr(16'hFF03, 16'h0002);
        rd(16'hFF01); @(negedge clk); chk("status_lost_clr", bus.rdata, 16'h2800);
        drv(16'hFF02, 16'h0000, 0, 1, 1, 16'h0001);
        @(negedge clk); chk("read_strobe_old", bus.rdata, 16'hBEEF);
        rd(16'hFF01); @(negedge clk); chk("read_strobe_status", bus.rdata, 16'h2800);
        rd(16'hFF02); @(negedge clk); chk("read_strobe_new", bus.rdata, 16'h0001);

        // Flush wins over a same-cycle pop
        for (int i = 0; i < 3; i++) wr(16'hFF00, 16'(16'h0011 * (i + 1)));
        rdy = 1;
        wr(16'hFF03, 16'h0001);
        rdy = 0;
        rd(16'hFF01);
        @(negedge clk);
        chk("flush_out_valid", 16'(bus.out_valid), 16'h0000);
        chk("flush_status", bus.rdata, 16'h0800);

        // Asynchronous reset mid-drain
        for (int i = 0; i < 3; i++) wr(16'hFF00, 16'(16'h0100 + i));
        rdy = 1;
        drv(16'hFF02, 16'h0000, 0, 1, 0, 16'h0000);
        #2;
        reset = 1;
        #1;
        chk("arst_out_valid", 16'(bus.out_valid), 16'h0000);
        chk("arst_out_data", bus.out_data, 16'h0000);
        chk("arst_rdata", bus.rdata, 16'h0000);
        repeat (2) @(posedge clk);
        #1 reset = 0;

        // Randomised traffic against the model
        for (int i = 0; i < 3000; i++) begin
            sel = $urandom_range(0, 15);
            rdy = ($urandom_range(0, 99) < ((i < 1500) ? 30 : 70));
            if (sel <= 6)       bus.addr = 16'hFF00;
            else if (sel <= 9)  bus.addr = 16'hFF01;
            else if (sel <= 12) bus.addr = 16'hFF02;
            else if (sel == 13) bus.addr = 16'hFF03;
            else                bus.addr = 16'($urandom);
            drv(bus.addr, 16'($urandom), $urandom_range(0, 1) == 1,
                $urandom_range(0, 1) == 1, $urandom_range(0, 3) == 0, 16'($urandom));
            if (bus.we) bus.re = 1'b0;
        end
        idle();
        @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
